// File: rtl/mat_operand_loader.sv
// Serial operand loader for an n x n dot-product array: buffers A row-major, stores B transposed,
// then presents both as packed vectors. Optional abort input enabled by MAT_LOADER_ABORT_EN.
module mat_operand_loader #(
  parameter int n = 4,
  parameter int k = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [k-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef MAT_LOADER_ABORT_EN
  input  logic             abort,
`endif
  output logic [n*n*k-1:0] rows_o,
  output logic [n*n*k-1:0] cols_o,
  output logic [1:0]       o_dbg_state
);

  localparam int NN = n * n;
  localparam int CW = $clog2(NN) + 1;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // Handshake: a beat is in_valid && in_ready at a rising edge; the output pair is taken
  // when out_valid && out_ready at a rising edge. in_data is ignored outside beats.
  state_t            r_state;
  state_t            w_state_next;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_next;
  logic              r_out_valid;
  logic [n*n*k-1:0]  r_rows;
  logic [n*n*k-1:0]  r_cols;
  logic              w_beat;
  logic              w_last;
  logic              w_abort;
  int                w_row;
  int                w_col;

`ifdef MAT_LOADER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign in_ready    = rst && (r_state != PRESENT);
  assign w_beat      = in_valid && in_ready && !w_abort;
  assign w_last      = (r_cnt == CW'(NN - 1));
  assign out_valid   = r_out_valid;
  assign rows_o      = r_rows;
  assign cols_o      = r_cols;
  assign o_dbg_state = r_state;

  always_comb begin
    w_row = int'(r_cnt) / n;
    w_col = int'(r_cnt) % n;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (w_abort) begin
      w_state_next = LOAD_A;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        LOAD_A: begin
          if (w_beat) begin
            if (w_last) begin
              w_cnt_next   = '0;
              w_state_next = LOAD_B;
            end else begin
              w_cnt_next = r_cnt + CW'(1);
            end
          end
        end
        LOAD_B: begin
          if (w_beat) begin
            if (w_last) begin
              w_cnt_next   = '0;
              w_state_next = PRESENT;
            end else begin
              w_cnt_next = r_cnt + CW'(1);
            end
          end
        end
        PRESENT: begin
          if (out_ready) begin
            w_state_next = LOAD_A;
          end
        end
        default: begin
          w_state_next = LOAD_A;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= LOAD_A;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_rows      <= '0;
      r_cols      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      // Registered from next state so out_valid rises right after the final B beat.
      r_out_valid <= (w_state_next == PRESENT);
      if (w_beat && (r_state == LOAD_A)) begin
        r_rows[(w_row * n + w_col) * k +: k] <= in_data;
      end
      if (w_beat && (r_state == LOAD_B)) begin
        r_cols[(w_col * n + w_row) * k +: k] <= in_data;
      end
    end
  end

endmodule
